// File: rtl/multicycle_control_unit_if.sv
// Control-to-datapath bundle for the RV32I multi-cycle control unit.
// master = control unit, slave = datapath.
interface multicycle_control_unit_if #(
   parameter int ALUOP_W = 2
);
   logic [6:0]         opcode;
   logic               mem_ready;
   logic               stall;
   logic               pc_write;
   logic               ir_write;
   logic               iord;
   logic               mem_read;
   logic               mem_write;
   logic [1:0]         alu_src_a;
   logic [1:0]         alu_src_b;
   logic [ALUOP_W-1:0] aluop;
   logic               branch;
   logic               reg_write;
   logic [1:0]         result_src;
   logic               trap;
   logic [1:0]         trap_cause;
   logic [2:0]         state_o;

   modport master (
      input  opcode, mem_ready, stall,
      output pc_write, ir_write, iord, mem_read, mem_write,
             alu_src_a, alu_src_b, aluop, branch, reg_write,
             result_src, trap, trap_cause, state_o
   );

   modport slave (
      output opcode, mem_ready, stall,
      input  pc_write, ir_write, iord, mem_read, mem_write,
             alu_src_a, alu_src_b, aluop, branch, reg_write,
             result_src, trap, trap_cause, state_o
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback over one
// shared memory port, with wait timeout, global stall and sticky trap state.
module multicycle_control_unit #(
   parameter int ALUOP_W     = 2,
   parameter int MEM_TIMEOUT = 16,
   parameter bit EN_JAL      = 1'b1
) (
   input logic                     clk,
   input logic                     rst_n,
   multicycle_control_unit_if.master bus
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CL_R     = 3'd0,
      CL_IALU  = 3'd1,
      CL_LOAD  = 3'd2,
      CL_STORE = 3'd3,
      CL_BR    = 3'd4,
      CL_JAL   = 3'd5
   } class_t;

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_r, state_nxt_s;
   class_t           class_r, class_nxt_s;
   logic [1:0]       cause_r, cause_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             timeout_s;

   logic               pc_write_s, ir_write_s, iord_s, mem_read_s, mem_write_s;
   logic [1:0]         alu_src_a_s, alu_src_b_s, result_src_s, trap_cause_s;
   logic [ALUOP_W-1:0] aluop_s;
   logic               branch_s, reg_write_s, trap_s;
   logic [2:0]         state_o_s;

   // State, instruction class, trap cause and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FETCH;
         class_r <= CL_R;
         cause_r <= 2'b00;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         class_r <= class_nxt_s;
         cause_r <= cause_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   assign timeout_s = (cnt_r == LAST_CNT) && !bus.mem_ready;

   // Next-state, class latch, trap cause and wait counter update.
   always_comb begin
      state_nxt_s = state_r;
      class_nxt_s = class_r;
      cause_nxt_s = cause_r;
      cnt_nxt_s   = cnt_r;
      if (bus.stall) begin
         state_nxt_s = state_r;
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (bus.mem_ready) begin
                  state_nxt_s = ST_DECODE;
               end else if (timeout_s) begin
                  state_nxt_s = ST_TRAP;
                  cause_nxt_s = 2'b10;
               end else begin
                  state_nxt_s = ST_FETCH;
               end
            end
            ST_DECODE: begin
               state_nxt_s = ST_EXEC;
               case (bus.opcode)
                  7'b0110011: class_nxt_s = CL_R;
                  7'b0010011: class_nxt_s = CL_IALU;
                  7'b0000011: class_nxt_s = CL_LOAD;
                  7'b0100011: class_nxt_s = CL_STORE;
                  7'b1100011: class_nxt_s = CL_BR;
                  7'b1101111: begin
                     if (EN_JAL) begin
                        class_nxt_s = CL_JAL;
                     end else begin
                        state_nxt_s = ST_TRAP;
                        cause_nxt_s = 2'b01;
                     end
                  end
                  default: begin
                     state_nxt_s = ST_TRAP;
                     cause_nxt_s = 2'b01;
                  end
               endcase
            end
            ST_EXEC: begin
               case (class_r)
                  CL_R, CL_IALU, CL_JAL: state_nxt_s = ST_WB;
                  CL_LOAD, CL_STORE:     state_nxt_s = ST_MEM;
                  CL_BR:                 state_nxt_s = ST_FETCH;
                  default:               state_nxt_s = ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (bus.mem_ready) begin
                  if (class_r == CL_LOAD) begin
                     state_nxt_s = ST_WB;
                  end else begin
                     state_nxt_s = ST_FETCH;
                  end
               end else if (timeout_s) begin
                  state_nxt_s = ST_TRAP;
                  cause_nxt_s = 2'b10;
               end else begin
                  state_nxt_s = ST_MEM;
               end
            end
            ST_WB:   state_nxt_s = ST_FETCH;
            ST_TRAP: state_nxt_s = ST_TRAP;
            default: state_nxt_s = ST_FETCH;
         endcase
         // Counter runs only while a memory access is held in place.
         if (state_nxt_s != state_r) begin
            cnt_nxt_s = '0;
         end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
         end else begin
            cnt_nxt_s = '0;
         end
      end
   end

   // Datapath controls decoded from state and class; strobes gated by stall and reset.
   always_comb begin
      pc_write_s   = 1'b0;
      ir_write_s   = 1'b0;
      iord_s       = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      alu_src_a_s  = 2'b00;
      alu_src_b_s  = 2'b00;
      aluop_s      = ALUOP_W'(2'b00);
      branch_s     = 1'b0;
      reg_write_s  = 1'b0;
      result_src_s = 2'b00;
      trap_s       = 1'b0;
      trap_cause_s = 2'b00;
      state_o_s    = 3'b000;
      if (!rst_n) begin
         trap_s = 1'b0;
      end else begin
         state_o_s    = state_r;
         trap_cause_s = cause_r;
         case (state_r)
            ST_FETCH: begin
               mem_read_s  = 1'b1;
               alu_src_b_s = 2'b10;
               ir_write_s  = bus.mem_ready && !bus.stall;
               pc_write_s  = bus.mem_ready && !bus.stall;
            end
            ST_DECODE: begin
               alu_src_a_s = 2'b01;
               alu_src_b_s = 2'b01;
            end
            ST_EXEC: begin
               case (class_r)
                  CL_R: begin
                     alu_src_a_s = 2'b10;
                     aluop_s     = ALUOP_W'(2'b10);
                  end
                  CL_IALU: begin
                     alu_src_a_s = 2'b10;
                     alu_src_b_s = 2'b01;
                     aluop_s     = ALUOP_W'(2'b10);
                  end
                  CL_LOAD, CL_STORE: begin
                     alu_src_a_s = 2'b10;
                     alu_src_b_s = 2'b01;
                  end
                  CL_BR: begin
                     alu_src_a_s = 2'b10;
                     aluop_s     = ALUOP_W'(2'b01);
                     branch_s    = !bus.stall;
                  end
                  CL_JAL:  pc_write_s = !bus.stall;
                  default: pc_write_s = 1'b0;
               endcase
            end
            ST_MEM: begin
               iord_s = 1'b1;
               if (class_r == CL_LOAD) begin
                  mem_read_s = 1'b1;
               end else begin
                  mem_write_s = !bus.stall;
               end
            end
            ST_WB: begin
               reg_write_s = !bus.stall;
               case (class_r)
                  CL_LOAD: result_src_s = 2'b01;
                  CL_JAL:  result_src_s = 2'b10;
                  default: result_src_s = 2'b00;
               endcase
            end
            ST_TRAP: trap_s = 1'b1;
            default: trap_s = 1'b0;
         endcase
      end
   end

   assign bus.pc_write   = pc_write_s;
   assign bus.ir_write   = ir_write_s;
   assign bus.iord       = iord_s;
   assign bus.mem_read   = mem_read_s;
   assign bus.mem_write  = mem_write_s;
   assign bus.alu_src_a  = alu_src_a_s;
   assign bus.alu_src_b  = alu_src_b_s;
   assign bus.aluop      = aluop_s;
   assign bus.branch     = branch_s;
   assign bus.reg_write  = reg_write_s;
   assign bus.result_src = result_src_s;
   assign bus.trap       = trap_s;
   assign bus.trap_cause = trap_cause_s;
   assign bus.state_o    = state_o_s;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (built with MEM_TIMEOUT = 4).
module tb_multicycle_control_unit;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;
   int   ir_cnt;
   int   rw_cnt;
   int   base;

   multicycle_control_unit_if #(.ALUOP_W(2)) bus ();

   multicycle_control_unit #(
      .ALUOP_W(2),
      .MEM_TIMEOUT(4),
      .EN_JAL(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.ir_write) ir_cnt = ir_cnt + 1;
      if (bus.reg_write) rw_cnt = rw_cnt + 1;
   end

   // {pc_write, ir_write, iord, mem_read, mem_write, branch, reg_write, trap}
   function automatic logic [7:0] strobes();
      return {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read,
              bus.mem_write, bus.branch, bus.reg_write, bus.trap};
   endfunction

   function automatic logic [20:0] all_outs();
      return {strobes(), bus.alu_src_a, bus.alu_src_b, bus.aluop,
              bus.result_src, bus.trap_cause, bus.state_o};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run = tests_run + 1;
      if (got !== exp) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      ir_cnt        = 0;
      rw_cnt        = 0;
      rst_n         = 1'b0;
      bus.opcode    = 7'd0;
      bus.mem_ready = 1'b0;
      bus.stall     = 1'b0;
      #3;
      check("reset_outs", 32'(all_outs()), 32'd0);

      // R-type, zero-wait memory: 0,1,2,4,0
      bus.opcode    = OP_R;
      bus.mem_ready = 1'b1;
      base = ir_cnt;
      release_rst();
      check("r_fetch_state", 32'(bus.state_o), 32'd0);
      check("r_fetch_strb", 32'(strobes()), 32'b1101_0000);
      check("r_fetch_srcb", 32'(bus.alu_src_b), 32'd2);
      tick();
      check("r_dec_state", 32'(bus.state_o), 32'd1);
      check("r_dec_src", 32'({bus.alu_src_a, bus.alu_src_b}), 32'b0101);
      tick();
      check("r_exec_state", 32'(bus.state_o), 32'd2);
      check("r_exec_ctl", 32'({bus.alu_src_a, bus.alu_src_b, bus.aluop}), 32'b10_00_10);
      check("r_exec_rw", 32'(bus.reg_write), 32'd0);
      bus.opcode = OP_LOAD;
      tick();
      check("r_wb_state", 32'(bus.state_o), 32'd4);
      check("r_wb_rw", 32'({bus.reg_write, bus.result_src}), 32'b1_00);
      tick();
      check("r_back_fetch", 32'(bus.state_o), 32'd0);
      check("r_ir_pulses", 32'(ir_cnt - base), 32'd1);

      // LOAD with three wait cycles in MEM
      tick();
      check("ld_dec_state", 32'(bus.state_o), 32'd1);
      tick();
      check("ld_exec_ctl", 32'({bus.alu_src_a, bus.alu_src_b, bus.aluop}), 32'b10_01_00);
      bus.mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("ld_mem_wait", 32'({bus.state_o, bus.mem_read, bus.iord}), 32'b011_1_1);
         tick();
      end
      bus.mem_ready = 1'b1;
      #1;
      check("ld_mem_last", 32'({bus.state_o, bus.mem_read, bus.iord, bus.trap}), 32'b011_1_1_0);
      tick();
      check("ld_wb", 32'({bus.state_o, bus.reg_write, bus.result_src}), 32'b100_1_01);
      tick();
      check("ld_back_fetch", 32'(bus.state_o), 32'd0);

      // Fetch timeout after four cycles without mem_ready
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("tmo_fetch_hold", 32'(bus.state_o), 32'd0);
         tick();
      end
      check("tmo_state", 32'(bus.state_o), 32'd5);
      check("tmo_trap", 32'({bus.trap, bus.trap_cause}), 32'b1_10);
      check("tmo_strobes", 32'(strobes()), 32'b0000_0001);
      rst_n = 1'b0;
      #1;
      check("tmo_reset_outs", 32'(all_outs()), 32'd0);
      bus.opcode = OP_R;
      release_rst();

      // mem_ready on the last allowed cycle wins over the timeout
      for (int i = 0; i < 3; i++) begin
         check("edge_fetch_hold", 32'(bus.state_o), 32'd0);
         tick();
      end
      bus.mem_ready = 1'b1;
      tick();
      check("edge_decode", 32'({bus.state_o, bus.trap}), 32'b001_0);
      tick();
      tick();
      tick();
      check("edge_back_fetch", 32'(bus.state_o), 32'd0);

      // STORE stalled for two cycles in MEM while mem_ready = 1
      bus.opcode = OP_STORE;
      tick();
      tick();
      check("st_exec_ctl", 32'({bus.alu_src_a, bus.alu_src_b, bus.aluop}), 32'b10_01_00);
      tick();
      bus.stall = 1'b1;
      #1;
      check("st_stall0", 32'({bus.state_o, bus.mem_write, bus.iord}), 32'b011_0_1);
      tick();
      check("st_stall1", 32'({bus.state_o, bus.mem_write}), 32'b011_0);
      tick();
      check("st_stall2", 32'({bus.state_o, bus.mem_write}), 32'b011_0);
      bus.stall     = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      check("st_unstall", 32'({bus.state_o, bus.mem_write, bus.mem_read}), 32'b011_1_0);
      tick();
      check("st_wait", 32'({bus.state_o, bus.mem_write}), 32'b011_1);
      bus.mem_ready = 1'b1;
      tick();
      check("st_back_fetch", 32'(bus.state_o), 32'd0);

      // Illegal opcode traps and stays trapped
      bus.opcode = OP_SYS;
      tick();
      check("ill_dec_state", 32'(bus.state_o), 32'd1);
      tick();
      check("ill_state", 32'(bus.state_o), 32'd5);
      check("ill_trap", 32'({bus.trap, bus.trap_cause}), 32'b1_01);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("ill_hold", 32'({bus.state_o, strobes()}), 32'b101_0000_0001);
      end
      rst_n = 1'b0;
      #1;
      check("ill_reset_outs", 32'(all_outs()), 32'd0);
      bus.opcode = OP_JAL;
      release_rst();
      check("ill_after_rst", 32'({bus.state_o, bus.mem_read, bus.trap_cause}), 32'b000_1_00);

      // JAL: PC written in EXEC, link written in WB
      tick();
      tick();
      check("jal_exec", 32'({bus.state_o, bus.pc_write}), 32'b010_1);
      tick();
      check("jal_wb", 32'({bus.state_o, bus.reg_write, bus.result_src}), 32'b100_1_10);
      tick();
      check("jal_back_fetch", 32'(bus.state_o), 32'd0);

      // Reset in the middle of a LOAD's MEM phase
      bus.opcode = OP_LOAD;
      base = rw_cnt;
      tick();
      tick();
      bus.mem_ready = 1'b0;
      tick();
      check("rst_mid_mem", 32'(bus.state_o), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_outs", 32'(all_outs()), 32'd0);
      bus.mem_ready = 1'b1;
      bus.opcode    = OP_BR;
      release_rst();
      check("rst_fetch", 32'({bus.state_o, bus.mem_read, bus.iord}), 32'b000_1_0);
      tick();
      tick();
      check("br_exec", 32'({bus.state_o, bus.branch, bus.aluop, bus.alu_src_a, bus.alu_src_b}),
            32'b010_1_01_10_00);
      tick();
      check("br_back_fetch", 32'(bus.state_o), 32'd0);
      check("rst_no_rw", 32'(rw_cnt - base), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
